// File: rtl/lab2_proc_imul_share_arbiter.sv
// Round-robin arbiter letting several cores share one iterative multiplier.
// One transaction is in flight at a time, and each response returns to the core that issued it.
module lab2_proc_imul_share_arbiter #(
    parameter int p_num_reqs = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [p_num_reqs-1:0]    req_val,
    output logic [p_num_reqs-1:0]    req_rdy,
    input  logic [64*p_num_reqs-1:0] req_msg,
    output logic [p_num_reqs-1:0]    resp_val,
    input  logic [p_num_reqs-1:0]    resp_rdy,
    output logic [32*p_num_reqs-1:0] resp_msg,
    output logic                     mul_req_val,
    input  logic                     mul_req_rdy,
    output logic [63:0]              mul_req_msg,
    input  logic                     mul_resp_val,
    output logic                     mul_resp_rdy,
    input  logic [31:0]              mul_resp_msg
);

    localparam int PW = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   owner_reg, owner_next;
    logic [PW-1:0]   prio_reg, prio_next;

    logic [p_num_reqs-1:0] grant;
    logic [PW-1:0]         grant_idx;
    logic                  grant_any;
    logic [PW:0]           cand_wide;
    logic [PW-1:0]         cand;

    // Scan from prio upward; the extra bit on cand_wide lets the wrap use a subtract instead of a modulo
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand_wide = '0;
        cand      = '0;
        for (int k = 0; k < p_num_reqs; k++) begin
            cand_wide = {1'b0, prio_reg} + (PW+1)'(k);
            if (cand_wide >= (PW+1)'(p_num_reqs)) begin
                cand_wide = cand_wide - (PW+1)'(p_num_reqs);
            end
            cand = cand_wide[PW-1:0];
            if (!grant_any && req_val[cand]) begin
                grant_any   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        prio_next  = prio_reg;
        case (state_reg)
            IDLE: begin
                if (grant_any && mul_req_rdy) begin
                    state_next = WAIT;
                    owner_next = grant_idx;
                    prio_next  = (grant_idx == PW'(p_num_reqs - 1)) ? '0 : grant_idx + PW'(1);
                end
            end
            WAIT: begin
                if (mul_resp_val && resp_rdy[owner_reg]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            owner_reg <= '0;
            prio_reg  <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            prio_reg  <= prio_next;
        end
    end

    // The grant is one-hot, so an AND-OR chain acts as the operand mux and yields zero with no grant
    logic [63:0] msg_chain [p_num_reqs+1];
    assign msg_chain[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < p_num_reqs; gi++) begin : g_core
            assign msg_chain[gi+1] = msg_chain[gi] | ({64{grant[gi]}} & req_msg[64*gi +: 64]);
            assign req_rdy[gi]  = ~reset & (state_reg == IDLE) & grant[gi] & mul_req_rdy;
            assign resp_val[gi] = ~reset & (state_reg == WAIT) & (owner_reg == PW'(gi)) & mul_resp_val;
            assign resp_msg[32*gi +: 32] = mul_resp_msg;
        end
    endgenerate

    assign mul_req_msg  = msg_chain[p_num_reqs];
    assign mul_req_val  = ~reset & (state_reg == IDLE) & (|req_val);
    assign mul_resp_rdy = ~reset & (state_reg == WAIT) & resp_rdy[owner_reg];

endmodule

// File: tb/tb_lab2_proc_imul_share_arbiter.sv
// Directed bench for the shared-multiplier arbiter; the bench itself plays the multiplier.
module tb_lab2_proc_imul_share_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_val, req_rdy, resp_val, resp_rdy;
    logic [64*N-1:0] req_msg;
    logic [32*N-1:0] resp_msg;
    logic            mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
    logic [63:0]     mul_req_msg;
    logic [31:0]     mul_resp_msg;

    lab2_proc_imul_share_arbiter #(.p_num_reqs(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_msg      (req_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_msg     (resp_msg),
        .mul_req_val  (mul_req_val),
        .mul_req_rdy  (mul_req_rdy),
        .mul_req_msg  (mul_req_msg),
        .mul_resp_val (mul_resp_val),
        .mul_resp_rdy (mul_resp_rdy),
        .mul_resp_msg (mul_resp_msg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Hand-computed operand/product table per core
    logic [31:0] op1  [N] = '{32'd2, 32'd5, 32'd3, 32'd10};
    logic [31:0] op2  [N] = '{32'd3, 32'd7, 32'd4, 32'd11};
    logic [31:0] prod [N] = '{32'd6, 32'd35, 32'd12, 32'd110};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full accept/response transaction with core c expected to win arbitration
    task automatic txn(input int c);
        logic [N-1:0] oh;
        oh    = '0;
        oh[c] = 1'b1;
        mul_req_rdy = 1'b1;
        #1;
        check_eq("grant_req_rdy", req_rdy, oh);
        check_eq("grant_mul_req_val", mul_req_val, 1);
        check_eq("grant_msg", mul_req_msg, {op1[c], op2[c]});
        step();
        mul_req_rdy = 1'b0;
        #1;
        check_eq("wait_req_rdy", req_rdy, 0);
        check_eq("wait_mul_req_val", mul_req_val, 0);
        mul_resp_val = 1'b1;
        mul_resp_msg = prod[c];
        #1;
        check_eq("resp_val", resp_val, oh);
        check_eq("resp_msg", resp_msg[32*c +: 32], prod[c]);
        check_eq("mul_resp_rdy", mul_resp_rdy, 1);
        step();
        mul_resp_val = 1'b0;
        $display("txn core=%0d op1=%0d op2=%0d prod=%0d", c, op1[c], op2[c], prod[c]);
    endtask

    initial begin
        req_msg      = {op1[3], op2[3], op1[2], op2[2], op1[1], op2[1], op1[0], op2[0]};
        reset        = 1'b1;
        req_val      = 4'b1111;
        resp_rdy     = 4'b1111;
        mul_req_rdy  = 1'b1;
        mul_resp_val = 1'b1;
        mul_resp_msg = 32'd0;

        // Outputs held low during reset regardless of inputs
        #1;
        repeat (2) begin
            check_eq("rst_req_rdy", req_rdy, 0);
            check_eq("rst_resp_val", resp_val, 0);
            check_eq("rst_mul_req_val", mul_req_val, 0);
            check_eq("rst_mul_resp_rdy", mul_resp_rdy, 0);
            step();
        end
        check_eq("rst_prio", dut.prio_reg, 0);
        reset        = 1'b0;
        mul_resp_val = 1'b0;
        mul_req_rdy  = 1'b0;
        req_val      = '0;
        step();

        // Single request from core 2
        req_val = 4'b0100;
        txn(2);
        req_val = '0;
        check_eq("single_prio", dut.prio_reg, 3);

        // All cores requesting after reset
        reset = 1'b1;
        step();
        reset   = 1'b0;
        req_val = 4'b1111;
        txn(0);
        txn(1);
        txn(2);
        txn(3);
        txn(0);
        req_val = '0;
        check_eq("rr_prio", dut.prio_reg, 1);

        // Wrap-around from prio 3
        req_val = 4'b0100;
        txn(2);
        check_eq("wrap_prio3", dut.prio_reg, 3);
        req_val = 4'b1010;
        txn(3);
        check_eq("wrap_prio0", dut.prio_reg, 0);
        txn(1);
        check_eq("wrap_prio2", dut.prio_reg, 2);
        req_val = '0;

        // Back-pressure on core 0 for 5 cycles while core 1 waits
        req_val     = 4'b0001;
        mul_req_rdy = 1'b1;
        #1;
        check_eq("bp_grant0", req_rdy, 4'b0001);
        step();
        req_val      = 4'b0010;
        resp_rdy     = 4'b1110;
        mul_resp_val = 1'b1;
        mul_resp_msg = prod[0];
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_mul_resp_rdy", mul_resp_rdy, 0);
            check_eq("bp_req_rdy", req_rdy, 0);
            check_eq("bp_resp_val", resp_val, 4'b0001);
            step();
        end
        resp_rdy = 4'b1111;
        #1;
        check_eq("bp_release_rdy", mul_resp_rdy, 1);
        check_eq("bp_release_msg", resp_msg[31:0], prod[0]);
        step();
        mul_resp_val = 1'b0;
        $display("txn core=0 op1=%0d op2=%0d prod=%0d (back-pressured)", op1[0], op2[0], prod[0]);
        mul_req_rdy = 1'b0;
        txn(1);
        req_val = '0;

        // Reset while waiting on core 1's response
        req_val     = 4'b0010;
        mul_req_rdy = 1'b1;
        #1;
        check_eq("rw_grant1", req_rdy, 4'b0010);
        step();
        mul_req_rdy  = 1'b0;
        req_val      = '0;
        reset        = 1'b1;
        mul_resp_val = 1'b1;
        mul_resp_msg = prod[1];
        #1;
        check_eq("rw_resp_val", resp_val, 0);
        check_eq("rw_mul_resp_rdy", mul_resp_rdy, 0);
        step();
        reset = 1'b0;
        #1;
        check_eq("rw_idle_resp_val", resp_val, 0);
        check_eq("rw_idle_mul_resp_rdy", mul_resp_rdy, 0);
        check_eq("rw_prio", dut.prio_reg, 0);
        mul_resp_val = 1'b0;
        req_val      = 4'b1000;
        txn(3);
        req_val = '0;

        // Stray multiplier response while idle
        mul_resp_val = 1'b1;
        mul_resp_msg = 32'd123;
        #1;
        check_eq("stray_mul_resp_rdy", mul_resp_rdy, 0);
        check_eq("stray_resp_val", resp_val, 0);
        check_eq("stray_mul_req_val", mul_req_val, 0);
        step();
        check_eq("stray_resp_val2", resp_val, 0);
        mul_resp_val = 1'b0;
        req_val      = 4'b0001;
        txn(0);
        req_val = '0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lab2_proc_imul_share_arbiter.md
# lab2_proc_imul_share_arbiter

Round-robin arbiter that lets `p_num_reqs` processor cores share one iterative integer multiplier. It has one val/rdy request port and one val/rdy response port per core, and one master port pair facing the multiplier. One transaction is in flight at a time. Each response is steered back to the core whose request was accepted. The block sits between the cores' X-stage multiplier handshakes and a single shared multiplier in the multi-core tile.

## Interface
- `p_num_reqs`, default 4: number of requesting cores. Legal range is 1..32. The pointer width is `max(1, $clog2(p_num_reqs))`.
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `req_val` in N: per-core request valid. Bit i belongs to core i.
- `req_rdy` out N: per-core request ready.
- `req_msg` in 64*N: per-core operands `{op1, op2}`. Core i uses bits [64i+63:64i].
- `resp_val` out N: per-core response valid.
- `resp_rdy` in N: per-core response ready.
- `resp_msg` out 32*N: per-core product. Every slice carries `mul_resp_msg`; only the owner's `resp_val` bit is asserted.
- `mul_req_val` out 1: request valid to the multiplier.
- `mul_req_rdy` in 1: multiplier ready to accept a request.
- `mul_req_msg` out 64: operands of the granted core.
- `mul_resp_val` in 1: multiplier response valid.
- `mul_resp_rdy` out 1: response ready to the multiplier.
- `mul_resp_msg` in 32: product from the multiplier.

## Operation
- **State machine**: two states, IDLE and WAIT. Registered state:
  - `state`
  - `owner` (pointer width)
  - `prio` (pointer width): the highest-priority core index.
- **IDLE**:
  - `grant` is one-hot. It selects the first core with `req_val` set, scanning from `prio` upward and wrapping from N-1 to 0.
  - `mul_req_val = |req_val`.
  - `mul_req_msg` = the granted core's slice. It is zero when nothing is granted.
  - `req_rdy[i] = grant[i] & mul_req_rdy`.
  - `mul_resp_rdy = 0`. All `resp_val = 0`.
- **IDLE to WAIT**: occurs on `mul_req_val & mul_req_rdy`. On that edge:
  - `owner` <= granted index.
  - `prio` <= (granted index + 1) mod N.
- **WAIT**:
  - All `req_rdy = 0` and `mul_req_val = 0`.
  - `resp_val[i] = (i == owner) & mul_resp_val`.
  - `mul_resp_rdy = resp_rdy[owner]`.
- **WAIT to IDLE**: occurs on `mul_resp_val & resp_rdy[owner]`.
- **Data handling**: operands and products pass through unmodified with no width conversion. The block has no data storage.
- **Spurious response in IDLE**: `mul_resp_val` is ignored. `mul_resp_rdy` stays 0 and no `resp_val` is raised.
- **Owner changes request mid-WAIT**: `req_val` from the owner during WAIT is not accepted. The owner must wait for IDLE like any other core.
- **N = 1**: `prio` and `owner` stay 0. Behaviour degenerates to a pass-through with one outstanding transaction.

## Timing
- **Reset**: while `reset` is high, every val/rdy output is 0 regardless of inputs. The edge with `reset` high sets `state` = IDLE, `owner` = 0, `prio` = 0.
- **Combinational paths**: grant and all handshake outputs are combinational from registered state and current inputs. No cycle is lost at arbitration.
- **Accept to response**: a request accepted at edge t makes the arbiter enter WAIT in cycle t+1. `resp_val` follows `mul_resp_val` in the same cycle it arrives.
- **Back-to-back issue**: when the response handshake completes at edge t, IDLE holds in cycle t+1 and a new request can be accepted at edge t+1. Minimum spacing between issues is one cycle plus the multiplier's latency.
- **Back-pressure**: if `resp_rdy[owner]` is low, the arbiter holds WAIT indefinitely and `mul_resp_rdy` stays low. `mul_resp_msg` is expected to be held stable by the multiplier.
- **Reset mid-transaction**: reset during WAIT returns to IDLE and drops the in-flight response. The multiplier is reset by the same signal.
- **Simultaneous events**: an accept and a release never occur in the same cycle, because they are in different states.

## Test plan
- **Single request, N=4**: core 2 sends `{3, 4}` with `resp_rdy = 4'b1111`.
  - `mul_req_msg = {3, 4}` and `req_rdy = 4'b0100`.
  - `resp_val = 4'b0100` with `resp_msg[2] = 12`.
  - `prio` becomes 3.
- **All cores requesting after reset**: all four `req_val` are held high with distinct operands.
  - Grants occur in order 0, 1, 2, 3, then 0.
  - Each response appears only on its owner's bit, e.g. core 1 `{5, 7}` returns 35.
- **Wrap-around**: with `prio` = 3, cores 1 and 3 both request.
  - Core 3 is granted first, then core 1.
  - `prio` takes the value 0 and then 2.
- **Back-pressure**: core 0's response arrives while `resp_rdy[0] = 0` for 5 cycles.
  - `mul_resp_rdy` stays 0, the arbiter stays in WAIT and all `req_rdy` stay 0.
  - Release happens on the 6th cycle. A pending core 1 request is accepted on the following cycle.
- **Reset**:
  - Reset asserted in WAIT: next cycle the state is IDLE, `prio` = 0, no `resp_val` is raised, and a new core 3 request is granted.
  - During reset with all `req_val` high: all outputs are 0.
- **Stray response**: `mul_resp_val` is pulsed in IDLE. `mul_resp_rdy` stays 0 and `resp_val` stays 0.
